// File: rtl/axis_rr_arbiter.sv
// Round-robin packet arbiter feeding one AXI-Stream register stage.
// A grant is held for a whole packet; the granted stream passes through a one-deep output register.
module axis_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  input  logic [NUM_REQ-1:0]            s_tlast,
  output logic [NUM_REQ-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy
);

  localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH+1)'(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [IDX_WIDTH-1:0]  r_ptr;
  logic [IDX_WIDTH-1:0]  r_grantIdx;
  logic [IDX_WIDTH-1:0]  w_winner;
  logic [IDX_WIDTH-1:0]  w_scanIdx;
  logic [IDX_WIDTH:0]    w_scanSum;
  logic                  w_found;
  logic                  w_outReady;
  logic                  w_accept;
  logic                  w_grantValid;
  logic                  w_grantLast;
  logic [DATA_WIDTH-1:0] w_grantData;
  logic [DATA_WIDTH-1:0] r_mData;
  logic                  r_mValid;
  logic                  r_mLast;

  // Scan requests starting at the priority pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_scanSum = '0;
    w_scanIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scanSum = {1'b0, r_ptr} + k[IDX_WIDTH:0];
      if (w_scanSum >= NUM_REQ_W) begin
        w_scanSum = w_scanSum - NUM_REQ_W;
      end
      w_scanIdx = w_scanSum[IDX_WIDTH-1:0];
      if (!w_found && s_tvalid[w_scanIdx]) begin
        w_found  = 1'b1;
        w_winner = w_scanIdx;
      end
    end
  end

  always_comb begin
    w_grantData  = '0;
    w_grantValid = 1'b0;
    w_grantLast  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grantIdx == i[IDX_WIDTH-1:0]) begin
        w_grantData  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_grantValid = s_tvalid[i];
        w_grantLast  = s_tlast[i];
      end
    end
  end

  assign w_outReady = !r_mValid || m_tready;
  assign w_accept   = (r_state == LOCK) && w_outReady && w_grantValid;

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_tready[i] = (r_state == LOCK) && w_outReady && (r_grantIdx == i[IDX_WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_found) w_nextState = LOCK;
      LOCK: if (w_accept && w_grantLast) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Grant bookkeeping and the one-deep output register; a drained beat is overwritten by a simultaneous accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_grantIdx <= '0;
      r_mData    <= '0;
      r_mValid   <= 1'b0;
      r_mLast    <= 1'b0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_grantIdx <= w_winner;
      end
      if (w_accept && w_grantLast) begin
        r_ptr <= (r_grantIdx == LAST_IDX) ? '0 : r_grantIdx + IDX_WIDTH'(1);
      end
      if (w_accept) begin
        r_mData  <= w_grantData;
        r_mLast  <= w_grantLast;
        r_mValid <= 1'b1;
      end else if (r_mValid && m_tready) begin
        r_mValid <= 1'b0;
      end
    end
  end

  assign m_tdata   = r_mData;
  assign m_tvalid  = r_mValid;
  assign m_tlast   = r_mLast;
  assign grant_idx = r_grantIdx;
  assign busy      = (r_state == LOCK);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized bench for axis_rr_arbiter against a packet-level reference model
// of round-robin grants, whole-packet locking and the one-deep output register.
module tb_axis_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic             clk;
  logic             reset;
  logic [NREQ*DW-1:0] s_tdata;
  logic [NREQ-1:0]  s_tvalid;
  logic [NREQ-1:0]  s_tlast;
  logic [NREQ-1:0]  s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [1:0]       grant_idx;
  logic             busy;

  axis_rr_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .IDX_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      reqQ[NREQ][$];
  bit         popped[NREQ];
  bit         holdOff[NREQ];
  int         assertCount;
  int         failCount;

  // Reference model: owner of the stage (-1 when none), next-priority requester, last grant, output register.
  int         mOwner;
  int         mPtr;
  int         mGrant;
  logic       mOutValid;
  logic       mOutLast;
  logic [7:0] mOutData;
  logic [NREQ-1:0] expReady;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOwner    = -1;
    mPtr      = 0;
    mGrant    = 0;
    mOutValid = 1'b0;
    mOutLast  = 1'b0;
    mOutData  = 8'h00;
  endtask

  task automatic addPacket(input int r, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.d = 8'($urandom_range(0, 255));
      bt.l = (b == len - 1);
      reqQ[r].push_back(bt);
    end
  endtask

  task automatic addFixed(input int r, input logic [7:0] d, input logic l);
    beat_t bt;
    bt.d = d;
    bt.l = l;
    reqQ[r].push_back(bt);
  endtask

  // Requesters hold tvalid until their beat is taken, then may pause before the next beat.
  task automatic applyStimulus(input int validPct, input int readyPct);
    for (int i = 0; i < NREQ; i++) begin
      if (popped[i]) begin
        s_tvalid[i] = 1'b0;
        popped[i]   = 1'b0;
      end
      if (!s_tvalid[i] && !holdOff[i] && reqQ[i].size() > 0 &&
          $urandom_range(0, 99) < validPct) begin
        s_tvalid[i]        = 1'b1;
        s_tdata[i*DW +: DW] = reqQ[i][0].d;
        s_tlast[i]         = reqQ[i][0].l;
      end
    end
    m_tready = ($urandom_range(0, 99) < readyPct);
  endtask

  task automatic modelStep();
    int  g;
    int  w;
    bit  found;
    if (mOwner < 0) begin
      if (mOutValid && m_tready) mOutValid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        w = (mPtr + k) % NREQ;
        if (!found && s_tvalid[w]) begin
          found  = 1'b1;
          mOwner = w;
          mGrant = w;
        end
      end
    end else begin
      g = mOwner;
      if (s_tvalid[g] && expReady[g]) begin
        mOutData  = reqQ[g][0].d;
        mOutLast  = reqQ[g][0].l;
        mOutValid = 1'b1;
        void'(reqQ[g].pop_front());
        popped[g] = 1'b1;
        if (mOutLast) begin
          mOwner = -1;
          mPtr   = (g + 1) % NREQ;
        end
      end else if (mOutValid && m_tready) begin
        mOutValid = 1'b0;
      end
    end
  endtask

  task automatic runCycle(input int validPct, input int readyPct);
    @(negedge clk);
    checkOutput("m_tvalid", m_tvalid, mOutValid);
    checkOutput("m_tdata", m_tdata, mOutData);
    checkOutput("m_tlast", m_tlast, mOutLast);
    checkOutput("grant_idx", grant_idx, mGrant);
    checkOutput("busy", busy, mOwner >= 0);
    applyStimulus(validPct, readyPct);
    #1;
    expReady = '0;
    if (mOwner >= 0 && (!mOutValid || m_tready)) expReady[mOwner] = 1'b1;
    checkOutput("s_tready", s_tready, expReady);
    modelStep();
  endtask

  function automatic bit anyPending();
    bit p;
    p = (mOwner >= 0) || mOutValid;
    for (int i = 0; i < NREQ; i++) if (reqQ[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain();
    for (int c = 0; c < 400 && anyPending(); c++) runCycle(100, 100);
    runCycle(100, 100);
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_m_tvalid"}, m_tvalid, 0);
    checkOutput({phase, "_m_tdata"}, m_tdata, 0);
    checkOutput({phase, "_m_tlast"}, m_tlast, 0);
    checkOutput({phase, "_grant_idx"}, grant_idx, 0);
    checkOutput({phase, "_busy"}, busy, 0);
    checkOutput({phase, "_s_tready"}, s_tready, 0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    s_tvalid    = '1;
    s_tdata     = '0;
    s_tlast     = '0;
    m_tready    = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      popped[i]  = 1'b0;
      holdOff[i] = 1'b0;
    end
    modelReset();
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    s_tvalid = '0;
    reset    = 1'b0;

    // Every requester streams 2-beat packets: grants rotate 0,1,2,3,0,...
    for (int r = 0; r < NREQ; r++) repeat (2) addPacket(r, 2);
    repeat (40) runCycle(100, 100);
    drain();

    addFixed(1, 8'h40, 1'b0);
    addFixed(1, 8'h20, 1'b0);
    addFixed(1, 8'h7F, 1'b1);
    repeat (8) runCycle(100, 100);
    drain();

    // Output stalls mid-packet for three cycles.
    addPacket(2, 5);
    repeat (3) runCycle(100, 100);
    repeat (3) runCycle(100, 0);
    repeat (6) runCycle(100, 100);
    drain();

    // Pointer sits at 3: single-beat packets from 3 then 0 exercise the wrap.
    addPacket(3, 1);
    addPacket(0, 1);
    repeat (8) runCycle(100, 100);
    drain();

    // Granted requester 2 stalls while requester 0 waits.
    addPacket(2, 3);
    repeat (2) runCycle(100, 100);
    holdOff[2] = 1'b1;
    addPacket(0, 2);
    repeat (4) runCycle(100, 100);
    holdOff[2] = 1'b0;
    drain();

    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (reqQ[r].size() == 0 && $urandom_range(0, 9) == 0) addPacket(r, $urandom_range(1, 4));
      end
      runCycle(60, 70);
    end
    drain();

    // Asynchronous reset while beat 2 of 4 sits in the output register.
    addPacket(1, 4);
    repeat (3) runCycle(100, 100);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkResetOutputs("midreset");
    for (int i = 0; i < NREQ; i++) begin
      reqQ[i].delete();
      popped[i] = 1'b0;
    end
    s_tvalid = '0;
    modelReset();
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < NREQ; r++) addPacket(r, 2);
    repeat (30) runCycle(100, 100);
    drain();

    @(negedge clk);
    checkOutput("final_busy", busy, 0);
    checkOutput("final_m_tvalid", m_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin arbiter that shares one AXI-Stream register stage (8-bit Q2.6 datapath) between NUM_REQ upstream requesters. Grants whole packets: once a requester is granted, it keeps the stage until a beat with tlast is accepted. The granted stream is then passed through a one-deep output register to the shared register stage. The block sits directly in front of the register stage and is its only master.

## Interface
Parameters:
- NUM_REQ, 4, number of requester streams (2..8)
- DATA_WIDTH, 8, beat width (Q2.6 fixed point by default; opaque to this block)
- IDX_WIDTH, 2, width of the grant index; must satisfy 2**IDX_WIDTH >= NUM_REQ

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high
- s_tdata  in  NUM_REQ*DATA_WIDTH  requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tvalid  in  NUM_REQ  per-requester valid
- s_tlast  in  NUM_REQ  per-requester end-of-packet
- s_tready  out  NUM_REQ  per-requester ready; at most one bit high in any cycle
- m_tdata  out  DATA_WIDTH  registered data to the register stage
- m_tvalid  out  1  registered valid
- m_tlast  out  1  registered last
- m_tready  in  1  ready from the register stage
- grant_idx  out  IDX_WIDTH  index of the current or most recent grant
- busy  out  1  high while in LOCK

## Operation
- FSM has two states: IDLE and LOCK.
- Priority pointer ptr, range 0..NUM_REQ-1. Reset value is 0.
- In IDLE, the arbiter scans s_tvalid starting at ptr and wrapping modulo NUM_REQ. The first set bit i is the winner. At the clock edge: grant_idx <= i, state <= LOCK.
- If no s_tvalid bit is set, the FSM stays in IDLE.
- In IDLE, all s_tready bits are 0.
- In LOCK, s_tready[grant_idx] = (!m_tvalid || m_tready); all other s_tready bits are 0. This is combinational.
- Beat accept: a beat is accepted when s_tvalid[g] && s_tready[g], with g = grant_idx. On accept:
  - m_tdata <= the slice of requester g
  - m_tlast <= s_tlast[g]
  - m_tvalid <= 1
- Output drain: if m_tvalid && m_tready and no new beat is accepted in the same cycle, m_tvalid <= 0.
- End of packet: when the accepted beat has s_tlast[g] = 1, then at the same edge state <= IDLE and ptr <= (g+1) mod NUM_REQ.
- grant_idx holds its value in IDLE.
- Requesters that drop tvalid mid-packet are not preempted. The lock persists until tlast is accepted.
- Data is passed unmodified; no width conversion.

## Timing
- Reset values: s_tready = 0, m_tvalid = 0, m_tdata = 0, m_tlast = 0, grant_idx = 0, busy = 0; state = IDLE, ptr = 0.
- Reset asserted mid-packet clears all of the above asynchronously. Any buffered beat is discarded, and the partial packet is not completed.
- Arbitration latency: request seen in IDLE at edge n; LOCK from n+1; s_tready can be high in cycle n+1; the first beat appears on m_* in cycle n+2.
- Throughput in LOCK is 1 beat per cycle while m_tready = 1.
- Between packets there is a gap of exactly 1 IDLE cycle on the input side.
- Backpressure: while m_tvalid && !m_tready, m_tdata, m_tlast and m_tvalid hold, and s_tready[g] = 0.
- Simultaneous drain and accept (m_tvalid && m_tready && accept): the register is overwritten with the new beat and m_tvalid stays 1.
- Single-beat packets (tlast on the first beat) are legal: one LOCK cycle, then back to IDLE.
- ptr wrap: when grant g = NUM_REQ-1, ptr returns to 0.

## Test plan
- Single requester: req1 sends a 3-beat packet 0x40, 0x20, 0x7F (tlast on the last beat), m_tready = 1 -> m_* shows the three beats in consecutive cycles starting 2 cycles after tvalid; m_tlast only on 0x7F; grant_idx = 1; then ptr = 2.
- Round-robin: all four requesters continuously send 2-beat packets -> grant order 0, 1, 2, 3, 0; exactly one IDLE cycle between packets; no interleaving of beats from different requesters.
- Backpressure: m_tready held 0 for 3 cycles mid-packet -> m_tdata stable, s_tready[g] = 0, no beat lost or duplicated after release.
- Lock hold: granted req2 drops tvalid for 4 cycles mid-packet while req0 is valid -> req0 is never granted until req2's tlast is accepted; next grant goes to req0 via the ptr = 3 wrap.
- Reset mid-packet: async reset during beat 2 of 4 -> all outputs 0 immediately; after release, req0 is granted first (ptr = 0).
- Single-beat packets from req3 and req0 back-to-back -> grant 3 then 0; the ptr wrap is exercised.
